// File: rtl/int_dispatch_if.sv
// Dispatch-to-integer-RS bundle: rename-side group in, CDB snoop, RS-side group out.
// master = dispatch stage, slave = its environment (rename, CDB, RS).
interface int_dispatch_if #(
  parameter int unsigned ID_WIDTH  = 2,
  parameter int unsigned CDB_WIDTH = 2,
  parameter int unsigned PRF_IDX   = 6,
  parameter int unsigned ROB_IDX   = 5,
  parameter int unsigned ARF_IDX   = 5
);
  // Rename side
  logic [ID_WIDTH-1:0]         rn_valid;
  logic                        rn_ready;
  logic [ID_WIDTH*ROB_IDX-1:0] rn_rob_id;
  logic [ID_WIDTH*PRF_IDX-1:0] rn_rs1_phy;
  logic [ID_WIDTH*PRF_IDX-1:0] rn_rs2_phy;
  logic [ID_WIDTH*PRF_IDX-1:0] rn_rd_phy;
  logic [ID_WIDTH-1:0]         rn_rd_en;
  logic [ID_WIDTH*ARF_IDX-1:0] rn_rd_arch;
  logic [ID_WIDTH-1:0]         rn_op1_sel;
  logic [ID_WIDTH-1:0]         rn_op2_sel;
  logic [ID_WIDTH*32-1:0]      rn_imm;
  logic [ID_WIDTH*4-1:0]       rn_fu_opcode;

  // CDB snoop
  logic [CDB_WIDTH-1:0]         cdb_valid;
  logic [CDB_WIDTH*PRF_IDX-1:0] cdb_rd_phy;

  // RS side
  logic [ID_WIDTH-1:0]         ds_valid;
  logic                        ds_ready;
  logic [ID_WIDTH*ROB_IDX-1:0] ds_rob_id;
  logic [ID_WIDTH*PRF_IDX-1:0] ds_rs1_phy;
  logic [ID_WIDTH*PRF_IDX-1:0] ds_rs2_phy;
  logic [ID_WIDTH*PRF_IDX-1:0] ds_rd_phy;
  logic [ID_WIDTH*ARF_IDX-1:0] ds_rd_arch;
  logic [ID_WIDTH-1:0]         ds_op1_sel;
  logic [ID_WIDTH-1:0]         ds_op2_sel;
  logic [ID_WIDTH*32-1:0]      ds_imm;
  logic [ID_WIDTH*4-1:0]       ds_fu_opcode;
  logic [ID_WIDTH-1:0]         ds_rs1_valid;
  logic [ID_WIDTH-1:0]         ds_rs2_valid;

  modport master (
    input  rn_valid, rn_rob_id, rn_rs1_phy, rn_rs2_phy, rn_rd_phy, rn_rd_en, rn_rd_arch,
    input  rn_op1_sel, rn_op2_sel, rn_imm, rn_fu_opcode,
    input  cdb_valid, cdb_rd_phy,
    input  ds_ready,
    output rn_ready,
    output ds_valid, ds_rob_id, ds_rs1_phy, ds_rs2_phy, ds_rd_phy, ds_rd_arch,
    output ds_op1_sel, ds_op2_sel, ds_imm, ds_fu_opcode, ds_rs1_valid, ds_rs2_valid
  );

  modport slave (
    output rn_valid, rn_rob_id, rn_rs1_phy, rn_rs2_phy, rn_rd_phy, rn_rd_en, rn_rd_arch,
    output rn_op1_sel, rn_op2_sel, rn_imm, rn_fu_opcode,
    output cdb_valid, cdb_rd_phy,
    output ds_ready,
    input  rn_ready,
    input  ds_valid, ds_rob_id, ds_rs1_phy, ds_rs2_phy, ds_rd_phy, ds_rd_arch,
    input  ds_op1_sel, ds_op2_sel, ds_imm, ds_fu_opcode, ds_rs1_valid, ds_rs2_valid
  );
endinterface

// File: rtl/int_dispatch.sv
// Integer dispatch stage: one-group skid register toward the RS plus the physical-register
// busy table that produces per-source ready bits with same-cycle CDB bypass.
module int_dispatch #(
  parameter int unsigned ID_WIDTH  = 2,
  parameter int unsigned CDB_WIDTH = 2,
  parameter int unsigned PRF_DEPTH = 64,
  parameter int unsigned PRF_IDX   = 6,
  parameter int unsigned ROB_IDX   = 5,
  parameter int unsigned ARF_IDX   = 5
) (
  input logic           clk,
  input logic           rst,
  int_dispatch_if.master dif
);

  logic                        stage_valid_q, stage_valid_d;
  logic [ID_WIDTH-1:0]         lane_valid_q;
  logic [ID_WIDTH*ROB_IDX-1:0] rob_id_q;
  logic [ID_WIDTH*PRF_IDX-1:0] rs1_phy_q;
  logic [ID_WIDTH*PRF_IDX-1:0] rs2_phy_q;
  logic [ID_WIDTH*PRF_IDX-1:0] rd_phy_q;
  logic [ID_WIDTH*ARF_IDX-1:0] rd_arch_q;
  logic [ID_WIDTH-1:0]         op1_sel_q;
  logic [ID_WIDTH-1:0]         op2_sel_q;
  logic [ID_WIDTH*32-1:0]      imm_q;
  logic [ID_WIDTH*4-1:0]       fu_opcode_q;
  logic [PRF_DEPTH-1:0]        busy_q, busy_d;

  logic accept;
  logic xfer;

  assign dif.rn_ready = !stage_valid_q || dif.ds_ready;
  assign accept       = dif.rn_ready && (|dif.rn_valid);
  assign xfer         = stage_valid_q && dif.ds_ready;

  always_comb begin
    stage_valid_d = stage_valid_q;
    if (accept) begin
      stage_valid_d = 1'b1;
    end else if (xfer) begin
      stage_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid_q <= 1'b0;
      lane_valid_q  <= '0;
    end else begin
      stage_valid_q <= stage_valid_d;
      if (accept) begin
        lane_valid_q <= dif.rn_valid;
      end
    end
  end

  // Payload needs no reset: it is only observed behind ds_valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      rob_id_q    <= dif.rn_rob_id;
      rs1_phy_q   <= dif.rn_rs1_phy;
      rs2_phy_q   <= dif.rn_rs2_phy;
      rd_phy_q    <= dif.rn_rd_phy;
      rd_arch_q   <= dif.rn_rd_arch;
      op1_sel_q   <= dif.rn_op1_sel;
      op2_sel_q   <= dif.rn_op2_sel;
      imm_q       <= dif.rn_imm;
      fu_opcode_q <= dif.rn_fu_opcode;
    end
  end

  // Clears first, then sets, so an accept that allocates a register being broadcast wins.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned k = 0; k < CDB_WIDTH; k++) begin
      if (dif.cdb_valid[k]) begin
        busy_d[dif.cdb_rd_phy[k*PRF_IDX +: PRF_IDX]] = 1'b0;
      end
    end
    if (accept) begin
      for (int unsigned i = 0; i < ID_WIDTH; i++) begin
        if (dif.rn_valid[i] && dif.rn_rd_en[i] &&
            (dif.rn_rd_phy[i*PRF_IDX +: PRF_IDX] != '0)) begin
          busy_d[dif.rn_rd_phy[i*PRF_IDX +: PRF_IDX]] = 1'b1;
        end
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  function automatic logic src_ready(input logic [PRF_IDX-1:0]           phy,
                                     input logic [PRF_DEPTH-1:0]         busy,
                                     input logic [CDB_WIDTH-1:0]         cdb_v,
                                     input logic [CDB_WIDTH*PRF_IDX-1:0] cdb_p);
    logic rdy;
    rdy = (phy == '0) || !busy[phy];
    for (int unsigned k = 0; k < CDB_WIDTH; k++) begin
      if (cdb_v[k] && (cdb_p[k*PRF_IDX +: PRF_IDX] == phy)) begin
        rdy = 1'b1;
      end
    end
    return rdy;
  endfunction

  always_comb begin
    dif.ds_rs1_valid = '0;
    dif.ds_rs2_valid = '0;
    for (int unsigned i = 0; i < ID_WIDTH; i++) begin
      dif.ds_rs1_valid[i] = src_ready(rs1_phy_q[i*PRF_IDX +: PRF_IDX], busy_q,
                                      dif.cdb_valid, dif.cdb_rd_phy);
      dif.ds_rs2_valid[i] = src_ready(rs2_phy_q[i*PRF_IDX +: PRF_IDX], busy_q,
                                      dif.cdb_valid, dif.cdb_rd_phy);
    end
  end

  assign dif.ds_valid     = stage_valid_q ? lane_valid_q : '0;
  assign dif.ds_rob_id    = rob_id_q;
  assign dif.ds_rs1_phy   = rs1_phy_q;
  assign dif.ds_rs2_phy   = rs2_phy_q;
  assign dif.ds_rd_phy    = rd_phy_q;
  assign dif.ds_rd_arch   = rd_arch_q;
  assign dif.ds_op1_sel   = op1_sel_q;
  assign dif.ds_op2_sel   = op2_sel_q;
  assign dif.ds_imm       = imm_q;
  assign dif.ds_fu_opcode = fu_opcode_q;

endmodule

// File: tb/tb_int_dispatch.sv
// Randomized bench for int_dispatch: directed scenarios followed by random traffic, all
// checked against a group-level model of the stage and a bit-vector busy table.
module tb_int_dispatch;
  localparam int W = 2;
  localparam int C = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int_dispatch_if dif ();

  int_dispatch u_dut (
    .clk (clk),
    .rst (rst),
    .dif (dif.master)
  );

  typedef struct {
    logic [4:0]  rob;
    logic [5:0]  rs1;
    logic [5:0]  rs2;
    logic [5:0]  rd;
    logic        rd_en;
    logic [4:0]  arch;
    logic        s1;
    logic        s2;
    logic [31:0] imm;
    logic [3:0]  op;
  } uop_t;

  uop_t         in_uop[W];
  logic [W-1:0] in_valid;
  logic [C-1:0] in_cv;
  logic [5:0]   in_cp[C];
  logic         in_ready;

  uop_t         m_stage[W];
  logic [W-1:0] m_lv;
  bit           m_sv;
  bit [63:0]    m_busy;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic uop_t rand_uop(input int unsigned range);
    uop_t u;
    u.rob   = 5'($urandom);
    u.rs1   = 6'($urandom_range(range));
    u.rs2   = 6'($urandom_range(range));
    u.rd    = 6'($urandom_range(range));
    u.rd_en = 1'($urandom);
    u.arch  = 5'($urandom);
    u.s1    = 1'($urandom);
    u.s2    = 1'($urandom);
    u.imm   = $urandom;
    u.op    = 4'($urandom);
    return u;
  endfunction

  task automatic set_lane(input int i, input logic [5:0] rs1, input logic [5:0] rs2,
                          input logic [5:0] rd, input logic rd_en);
    in_uop[i]       = rand_uop(63);
    in_uop[i].rs1   = rs1;
    in_uop[i].rs2   = rs2;
    in_uop[i].rd    = rd;
    in_uop[i].rd_en = rd_en;
  endtask

  task automatic drive();
    for (int i = 0; i < W; i++) begin
      dif.rn_rob_id[i*5 +: 5]     = in_uop[i].rob;
      dif.rn_rs1_phy[i*6 +: 6]    = in_uop[i].rs1;
      dif.rn_rs2_phy[i*6 +: 6]    = in_uop[i].rs2;
      dif.rn_rd_phy[i*6 +: 6]     = in_uop[i].rd;
      dif.rn_rd_en[i]             = in_uop[i].rd_en;
      dif.rn_rd_arch[i*5 +: 5]    = in_uop[i].arch;
      dif.rn_op1_sel[i]           = in_uop[i].s1;
      dif.rn_op2_sel[i]           = in_uop[i].s2;
      dif.rn_imm[i*32 +: 32]      = in_uop[i].imm;
      dif.rn_fu_opcode[i*4 +: 4]  = in_uop[i].op;
    end
    for (int k = 0; k < C; k++) dif.cdb_rd_phy[k*6 +: 6] = in_cp[k];
    dif.rn_valid  = in_valid;
    dif.cdb_valid = in_cv;
    dif.ds_ready  = in_ready;
  endtask

  function automatic bit m_src_ready(input logic [5:0] p);
    bit r;
    r = (p == 6'd0) || !m_busy[p];
    for (int k = 0; k < C; k++) if (in_cv[k] && in_cp[k] == p) r = 1'b1;
    return r;
  endfunction

  task automatic check_model();
    logic [W-1:0] exp_v;
    exp_v = m_sv ? m_lv : '0;
    check("rn_ready", 64'(dif.rn_ready), 64'(!m_sv || in_ready));
    check("ds_valid", 64'(dif.ds_valid), 64'(exp_v));
    for (int i = 0; i < W; i++) begin
      if (exp_v[i]) begin
        check($sformatf("rob%0d", i),  64'(dif.ds_rob_id[i*5 +: 5]),    64'(m_stage[i].rob));
        check($sformatf("rs1p%0d", i), 64'(dif.ds_rs1_phy[i*6 +: 6]),   64'(m_stage[i].rs1));
        check($sformatf("rs2p%0d", i), 64'(dif.ds_rs2_phy[i*6 +: 6]),   64'(m_stage[i].rs2));
        check($sformatf("rdp%0d", i),  64'(dif.ds_rd_phy[i*6 +: 6]),    64'(m_stage[i].rd));
        check($sformatf("arch%0d", i), 64'(dif.ds_rd_arch[i*5 +: 5]),   64'(m_stage[i].arch));
        check($sformatf("sel%0d", i),  64'({dif.ds_op1_sel[i], dif.ds_op2_sel[i]}),
              64'({m_stage[i].s1, m_stage[i].s2}));
        check($sformatf("imm%0d", i),  64'(dif.ds_imm[i*32 +: 32]),     64'(m_stage[i].imm));
        check($sformatf("op%0d", i),   64'(dif.ds_fu_opcode[i*4 +: 4]), 64'(m_stage[i].op));
        check($sformatf("rs1v%0d", i), 64'(dif.ds_rs1_valid[i]), 64'(m_src_ready(m_stage[i].rs1)));
        check($sformatf("rs2v%0d", i), 64'(dif.ds_rs2_valid[i]), 64'(m_src_ready(m_stage[i].rs2)));
      end
    end
  endtask

  task automatic update_model();
    bit acc;
    if (rst) begin
      m_sv = 1'b0;
      m_lv = '0;
      m_busy = '0;
      return;
    end
    acc = (!m_sv || in_ready) && (|in_valid);
    for (int k = 0; k < C; k++) if (in_cv[k]) m_busy[in_cp[k]] = 1'b0;
    if (acc) begin
      for (int i = 0; i < W; i++)
        if (in_valid[i] && in_uop[i].rd_en && in_uop[i].rd != 6'd0) m_busy[in_uop[i].rd] = 1'b1;
      m_stage = in_uop;
      m_lv = in_valid;
      m_sv = 1'b1;
    end else if (m_sv && in_ready) begin
      m_sv = 1'b0;
    end
  endtask

  task automatic sample();
    drive();
    @(negedge clk);
    check_model();
  endtask

  task automatic adv();
    update_model();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample();
    adv();
  endtask

  logic [31:0] held_imm;
  logic [4:0]  held_rob;
  int          n_x;

  initial begin
    for (int i = 0; i < W; i++) in_uop[i] = rand_uop(63);
    for (int k = 0; k < C; k++) in_cp[k] = 6'd0;
    in_valid = '0;
    in_cv    = '0;
    in_ready = 1'b1;
    m_sv = 1'b0;
    m_lv = '0;
    m_busy = '0;
    rst = 1'b1;
    drive();
    adv();
    adv();
    rst = 1'b0;

    sample();
    check("rst_rn_ready", 64'(dif.rn_ready), 64'd1);
    check("rst_ds_valid", 64'(dif.ds_valid), 64'd0);
    adv();

    // Basic group
    set_lane(0, 6'd1, 6'd2, 6'd5, 1'b1);
    set_lane(1, 6'd1, 6'd2, 6'd6, 1'b1);
    in_valid = 2'b11;
    step();
    in_valid = 2'b00;
    sample();
    check("t1_valid", 64'(dif.ds_valid), 64'd3);
    check("t1_rs1v", 64'(dif.ds_rs1_valid), 64'd3);
    check("t1_rs2v", 64'(dif.ds_rs2_valid), 64'd3);
    adv();
    sample();
    check("t1_drain", 64'(dif.ds_valid), 64'd0);
    adv();

    // Intra-group dependency, then a later reader of p7 until the CDB frees it
    set_lane(0, 6'd1, 6'd2, 6'd7, 1'b1);
    set_lane(1, 6'd7, 6'd2, 6'd8, 1'b1);
    in_valid = 2'b11;
    step();
    set_lane(0, 6'd7, 6'd1, 6'd10, 1'b1);
    set_lane(1, 6'd3, 6'd4, 6'd11, 1'b0);
    sample();
    check("dep_rs1v", 64'(dif.ds_rs1_valid), 64'd1);
    adv();
    in_valid = 2'b00;
    in_ready = 1'b0;
    sample();
    check("dep_follow", 64'(dif.ds_rs1_valid[0]), 64'd0);
    adv();
    in_cv = 2'b01;
    in_cp[0] = 6'd7;
    sample();
    check("dep_wake", 64'(dif.ds_rs1_valid[0]), 64'd1);
    adv();
    in_cv = 2'b00;
    in_ready = 1'b1;
    step();

    // Stall with a wakeup on CDB port 1 in the second stall cycle
    set_lane(0, 6'd1, 6'd2, 6'd9, 1'b1);
    set_lane(1, 6'd1, 6'd2, 6'd13, 1'b1);
    in_valid = 2'b11;
    step();
    set_lane(0, 6'd1, 6'd9, 6'd14, 1'b1);
    set_lane(1, 6'd2, 6'd1, 6'd15, 1'b1);
    step();
    set_lane(0, 6'd20, 6'd21, 6'd22, 1'b1);
    set_lane(1, 6'd20, 6'd21, 6'd23, 1'b1);
    in_ready = 1'b0;
    sample();
    check("stall_rn_ready", 64'(dif.rn_ready), 64'd0);
    check("stall_rs2v", 64'(dif.ds_rs2_valid[0]), 64'd0);
    held_imm = dif.ds_imm[31:0];
    held_rob = dif.ds_rob_id[4:0];
    adv();
    in_cv = 2'b10;
    in_cp[1] = 6'd9;
    sample();
    check("wake_rise", 64'(dif.ds_rs2_valid[0]), 64'd1);
    check("stall_imm", 64'(dif.ds_imm[31:0]), 64'(held_imm));
    adv();
    in_cv = 2'b00;
    sample();
    check("wake_stay", 64'(dif.ds_rs2_valid[0]), 64'd1);
    check("stall_rob", 64'(dif.ds_rob_id[4:0]), 64'(held_rob));
    adv();
    in_valid = 2'b00;
    in_ready = 1'b1;
    step();
    step();

    // Set/clear collision on p12: set wins
    set_lane(0, 6'd1, 6'd2, 6'd12, 1'b1);
    in_valid = 2'b01;
    in_cv = 2'b01;
    in_cp[0] = 6'd12;
    step();
    in_cv = 2'b00;
    set_lane(0, 6'd12, 6'd1, 6'd16, 1'b1);
    step();
    in_valid = 2'b00;
    sample();
    check("coll_rs1v", 64'(dif.ds_rs1_valid[0]), 64'd0);
    adv();

    // rd_en=0 and rd_phy=0 never mark busy
    set_lane(0, 6'd1, 6'd2, 6'd3, 1'b0);
    set_lane(1, 6'd1, 6'd2, 6'd0, 1'b1);
    in_valid = 2'b11;
    step();
    set_lane(0, 6'd3, 6'd0, 6'd17, 1'b1);
    set_lane(1, 6'd0, 6'd3, 6'd18, 1'b1);
    step();
    in_valid = 2'b00;
    sample();
    check("x0_rs1v", 64'(dif.ds_rs1_valid), 64'd3);
    check("x0_rs2v", 64'(dif.ds_rs2_valid), 64'd3);
    adv();
    step();

    // Back-to-back throughput
    n_x = 0;
    for (int g = 0; g < 8; g++) begin
      for (int i = 0; i < W; i++) in_uop[i] = rand_uop(63);
      in_valid = 2'b11;
      sample();
      if (|dif.ds_valid) n_x++;
      adv();
    end
    in_valid = 2'b00;
    sample();
    if (|dif.ds_valid) n_x++;
    adv();
    check("thru_xfers", 64'(n_x), 64'd8);

    // Reset while a group is held drops it and clears the busy table
    set_lane(0, 6'd1, 6'd2, 6'd20, 1'b1);
    set_lane(1, 6'd1, 6'd2, 6'd21, 1'b1);
    in_valid = 2'b11;
    step();
    in_valid = 2'b00;
    in_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_ready = 1'b1;
    sample();
    check("rst_drop", 64'(dif.ds_valid), 64'd0);
    adv();
    set_lane(0, 6'd20, 6'd21, 6'd1, 1'b0);
    set_lane(1, 6'd21, 6'd20, 6'd0, 1'b0);
    in_valid = 2'b11;
    step();
    in_valid = 2'b00;
    sample();
    check("rst_busy_rs1", 64'(dif.ds_rs1_valid), 64'd3);
    check("rst_busy_rs2", 64'(dif.ds_rs2_valid), 64'd3);
    adv();

    // Random traffic on a narrow register range to provoke hazards and collisions
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < W; i++) in_uop[i] = rand_uop(15);
      in_valid = 2'($urandom);
      in_cv    = 2'($urandom);
      for (int k = 0; k < C; k++) in_cp[k] = 6'($urandom_range(15));
      in_ready = ($urandom_range(3) != 0);
      rst      = ($urandom_range(120) == 0);
      step();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
